i2s_tx: RTL
===========

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter BIT, default 24: sample width in bits.
REQ-002 Parameter SLOT, default 32: BCK periods per channel slot; SLOT SHALL be at least BIT+1.
REQ-003 Parameter MCK_PER_BCK, default 4: MCK cycles per BCK period; even and at least 2.
REQ-004 Parameter DEPTH, default 4: FIFO depth in stereo frames; power of 2.
REQ-005 mck_i  in  1  master clock; all logic clocked on its rising edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-low.
REQ-007 en_i  in  1  transmit enable, sampled only at frame boundaries.
REQ-008 l_data_i  in  BIT  left sample, signed two's complement.
REQ-009 r_data_i  in  BIT  right sample, signed two's complement.
REQ-010 valid_i  in  1  l_data_i and r_data_i hold a frame.
REQ-011 ready_o  out  1  FIFO can accept a frame.
REQ-012 bck_o  out  1  bit clock, MCK/MCK_PER_BCK, 50% duty.
REQ-013 lrck_o  out  1  word select: 0 = left, 1 = right.
REQ-014 sd_o  out  1  serial data.
REQ-015 underrun_o  out  1  one-MCK pulse when a frame starts with the FIFO empty.
REQ-016 level_o  out  log2(DEPTH)+1  FIFO occupancy in frames.

Function
REQ-017 Push: a frame is accepted on a rising MCK edge when valid_i=1 and ready_o=1; ready_o SHALL be 1 exactly when level_o < DEPTH.
REQ-018 FIFO SHALL accept pushes regardless of en_i or state.
REQ-019 State machine: IDLE and RUN. IDLE goes to RUN at the first MCK edge with en_i=1. RUN goes to IDLE only at a frame boundary where en_i=0.
REQ-020 In IDLE: bck_o=0, lrck_o=0, sd_o=0; divider and bit counter held at 0.
REQ-021 In RUN, divider div 0..MCK_PER_BCK-1 wraps. bck_o goes 0 at the edge where div wraps to 0. bck_o goes 1 at the edge where div reaches MCK_PER_BCK/2.
REQ-022 Falling BCK edge: the MCK edge where bck_o goes 0. lrck_o and sd_o SHALL change only there, so the receiver can sample at rising BCK.
REQ-023 Bit counter bc runs 0..2*SLOT-1 and advances once per falling BCK edge.
REQ-024 lrck_o=0 for bc < SLOT and lrck_o=1 otherwise.
REQ-025 Slot position k = bc mod SLOT. sd_o = 0 at k=0, data[BIT-k] for k=1..BIT (MSB first, one BCK after the LRCK edge), and 0 for k > BIT.
REQ-026 Frame boundary: the falling BCK edge at which bc becomes 0. Entry to RUN counts as a boundary.
REQ-027 At each boundary in RUN with level_o > 0: pop one frame into the L and R shift registers; level_o decrements.
REQ-028 At a boundary with level_o = 0: load zeros into both channels and pulse underrun_o for exactly one MCK.
REQ-029 A push and a pop in the same MCK cycle SHALL leave level_o unchanged.
REQ-030 The empty test at a boundary uses the pre-edge level, so a push in that same cycle does not prevent the underrun; that frame is sent in the next frame period.
REQ-031 Frame period SHALL be 2*SLOT*MCK_PER_BCK MCK cycles (256 at defaults).
REQ-032 First falling BCK edge SHALL occur MCK_PER_BCK MCK cycles after entering RUN.

Reset
REQ-033 While rst_i=0, all of the following SHALL hold immediately, independent of mck_i: bck_o=0, lrck_o=0, sd_o=0, underrun_o=0, level_o=0, ready_o=1, state IDLE, FIFO pointers 0, shift registers 0.
REQ-034 rst_i asserted mid-frame SHALL abort the frame; no partial bits are emitted after rst_i is released.
REQ-035 After release, operation SHALL follow REQ-019.

Verification
REQ-036 Reset, en_i=1, push L=0x800001 and R=0x7FFFFE before the first boundary. Required: left slot sd_o=0, then 1, 22 zeros, 1, then 7 zeros. Right slot sd_o=0, then 0, 22 ones, 0, then 7 zeros. lrck_o toggles every 128 MCK.
REQ-037 en_i=1 with no pushes. Required: underrun_o pulses once per 256 MCK, sd_o constantly 0, bck_o and lrck_o keep running.
REQ-038 Push 5 frames back-to-back with en_i=0. Required: first 4 accepted, ready_o=0, level_o=4. After en_i=1, the 5th frame is accepted in the cycle after the first pop.
REQ-039 Drop en_i at bc=10. Required: the frame completes all 64 BCK, then bck_o, lrck_o and sd_o go to 0 at the boundary; a queued frame is not popped.
REQ-040 Assert rst_i at bc=40 with level_o=2. Required: outputs go to 0 in the same cycle and level_o=0.
REQ-041 Push while level_o=0 in the same MCK cycle as a boundary. Required: underrun_o pulses, level_o=1 afterwards, and that frame is output in the following frame period.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter with a stereo-frame FIFO, BCK/LRCK generation and underrun flag.
//    mck_i        master clock, everything runs on its rising edge
//    rst_i        asynchronous active-low reset
//    en_i         transmit enable, honoured at frame boundaries
//    l_data_i     left sample (two's complement)
//    r_data_i     right sample (two's complement)
//    valid_i      push request for {l_data_i, r_data_i}
//    ready_o      FIFO has room for a frame
//    bck_o        bit clock, mck_i / MCK_PER_BCK
//    lrck_o       word select, 0 = left, 1 = right
//    sd_o         serial data, MSB first, one BCK after the LRCK edge
//    underrun_o   one-cycle pulse when a frame starts with the FIFO empty
//    level_o      FIFO occupancy in frames
module i2s_tx #(
   parameter int BIT         = 24,
   parameter int SLOT        = 32,
   parameter int MCK_PER_BCK = 4,
   parameter int DEPTH       = 4
) (
   input  logic                       mck_i,
   input  logic                       rst_i,
   input  logic                       en_i,
   input  logic [BIT-1:0]             l_data_i,
   input  logic [BIT-1:0]             r_data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic                       bck_o,
   output logic                       lrck_o,
   output logic                       sd_o,
   output logic                       underrun_o,
   output logic [$clog2(DEPTH):0]     level_o
);
   localparam int AW  = $clog2(DEPTH);
   localparam int LW  = AW + 1;
   localparam int BCW = $clog2(2 * SLOT);
   localparam int DW  = $clog2(MCK_PER_BCK);
   localparam logic [DW-1:0]  D_LAST  = DW'(MCK_PER_BCK - 1);
   localparam logic [DW-1:0]  D_HALF  = DW'(MCK_PER_BCK / 2 - 1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(2 * SLOT - 1);
   localparam logic [BCW-1:0] S_C     = BCW'(SLOT);
   localparam logic [BCW-1:0] BIT_C   = BCW'(BIT);
   localparam logic [LW-1:0]  DEPTH_C = LW'(DEPTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q, state_d;
   logic [DW-1:0]    div_q, div_d;
   logic [BCW-1:0]   bc_q, bc_d;
   logic             bck_q, bck_d, lrck_q, lrck_d, sd_q, sd_d, und_q, und_d;
   logic [BIT-1:0]   l_sh_q, l_sh_d, r_sh_q, r_sh_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [2*BIT-1:0] mem_q [DEPTH];

   logic             run, push, fall, wrap, bnd, pop, act, hi, dbit;
   logic [BCW-1:0]   bc_nx, k;
   logic [2*BIT-1:0] head;

   always_comb begin
      run      = state_q == RUN;
      push     = valid_i && ready_o;
      fall     = run && div_q == D_LAST;
      wrap     = fall && bc_q == BC_LAST;
      // entering RUN counts as a frame boundary, as does every wrap that keeps running
      bnd      = en_i && (!run || wrap);
      state_d  = (run ? !(wrap && !en_i) : en_i) ? RUN : IDLE;
      // act: already running and staying in RUN; entry and exit both force the counters to 0
      act      = run && state_d == RUN;
      pop      = bnd && level_q != '0;
      head     = mem_q[rd_ptr_q];
      bc_nx    = wrap ? '0 : bc_q + BCW'(1);
      hi       = bc_nx >= S_C;
      k        = hi ? bc_nx - S_C : bc_nx;
      dbit     = k != '0 && k <= BIT_C;
      div_d    = act ? (fall ? '0 : div_q + DW'(1)) : '0;
      bck_d    = act && !fall && (div_q == D_HALF || bck_q);
      bc_d     = act ? (fall ? bc_nx : bc_q) : '0;
      lrck_d   = act ? (fall ? hi : lrck_q) : 1'b0;
      sd_d     = act ? (fall ? dbit && (hi ? r_sh_q[BIT-1] : l_sh_q[BIT-1]) : sd_q) : 1'b0;
      und_d    = bnd && level_q == '0;
      l_sh_d   = bnd ? (pop ? head[2*BIT-1:BIT] : '0) : (act && fall && dbit && !hi) ? l_sh_q << 1 : l_sh_q;
      r_sh_d   = bnd ? (pop ? head[BIT-1:0] : '0) : (act && fall && dbit && hi) ? r_sh_q << 1 : r_sh_q;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      level_d  = level_q + LW'(push) - LW'(pop);
   end

   always_ff @(posedge mck_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bc_q     <= '0;
         bck_q    <= 1'b0;
         lrck_q   <= 1'b0;
         sd_q     <= 1'b0;
         und_q    <= 1'b0;
         l_sh_q   <= '0;
         r_sh_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         bc_q     <= bc_d;
         bck_q    <= bck_d;
         lrck_q   <= lrck_d;
         sd_q     <= sd_d;
         und_q    <= und_d;
         l_sh_q   <= l_sh_d;
         r_sh_q   <= r_sh_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge mck_i) begin
      if (push) mem_q[wr_ptr_q] <= {l_data_i, r_data_i};
   end

   assign ready_o    = level_q < DEPTH_C;
   assign bck_o      = bck_q;
   assign lrck_o     = lrck_q;
   assign sd_o       = sd_q;
   assign underrun_o = und_q;
   assign level_o    = level_q;
endmodule
